// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl
// Scan scheduler for a six-digit multiplexed seven-segment display.
// A producer hands over complete six-digit frames through a valid/ready
// handshake. Each frame is held in a pending buffer and is copied into the
// displayed (active) buffer only at a frame boundary, so one scan never
// shows a mix of two frames. Every scan slot begins with an all-off blank
// interval against ghosting. Digits with a cleared mask bit are skipped.
// A 4-bit brightness value sets the on-time in SUB_CYC steps.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_frame_seg[41:0] digit k segments {a..g} at [7k+6:7k], 1 = lit
//   i_frame_dp[5:0]  digit k decimal point at bit k, 1 = lit
//   i_frame_valid    producer offers a frame
//   o_frame_ready    pending buffer empty, a frame can be accepted
//   i_digit_mask[5:0] 1 = digit k takes part in the scan
//   i_bright[3:0]    on-time in steps, 0..15
//   o_seg[6:0]       segment drive for the current digit
//   o_seg_dp         decimal-point drive for the current digit
//   o_seg_enb[5:0]   digit enables, active-low, at most one bit low
//   o_frame_start    one-cycle pulse on the first cycle of a frame
module fnd_scan_ctrl #(
  parameter int BLANK_CYC = 50,
  parameter int SUB_CYC   = 330
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [41:0] i_frame_seg,
  input  logic [5:0]  i_frame_dp,
  input  logic        i_frame_valid,
  output logic        o_frame_ready,
  input  logic [5:0]  i_digit_mask,
  input  logic [3:0]  i_bright,
  output logic [6:0]  o_seg,
  output logic        o_seg_dp,
  output logic [5:0]  o_seg_enb,
  output logic        o_frame_start
);

  localparam int SLOT_CYC = BLANK_CYC + 15 * SUB_CYC;
  localparam int CW       = $clog2(SLOT_CYC);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] SUB_W      = CW'(SUB_CYC);

  typedef enum logic [1:0] {IDLE, BLANK, ON, OFF} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [3:0]    bright_q;
  logic [41:0]   act_seg_q;
  logic [5:0]    act_dp_q;
  logic [41:0]   pend_seg_q;
  logic [5:0]    pend_dp_q;
  logic          pending_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [5:0]    enb_q;
  logic          start_q;

  logic [6:0]    digit_seg [6];
  logic [2:0]    idx_d;
  logic [CW-1:0] on_last;
  logic          boundary;
  logic          slot_end;
  logic          slot_go;

  // Next enabled digit strictly above cur, wrapping 5 -> 0. Starting from
  // cur = 5 yields the lowest enabled digit.
  function automatic logic [2:0] pick_next(input logic [5:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic       found;
    int         cand;
    logic [2:0] c3;
    r     = cur;
    found = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cand = (int'(cur) + k) % 6;
      c3   = cand[2:0];
      if (!found && m[c3]) begin
        r     = c3;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < 6; gi++) begin : g_digit
    assign digit_seg[gi] = act_seg_q[7*gi +: 7];
  end

  always_comb begin
    idx_d    = pick_next(i_digit_mask, (state_q == IDLE) ? 3'd5 : idx_q);
    // The boundary rule only looks at indices: wrapping around (or staying
    // on a single digit) closes the frame.
    boundary = (state_q == IDLE) || (idx_d <= idx_q);
    // Last counter value of the ON phase.
    on_last  = BLANK_LAST + CW'(bright_q) * SUB_W;
    slot_end = ((state_q == ON) || (state_q == OFF)) && (cnt_q == SLOT_LAST);
    slot_go  = ((state_q == IDLE) || slot_end) && (i_digit_mask != 6'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= 3'd5;
      bright_q   <= 4'd0;
      act_seg_q  <= '0;
      act_dp_q   <= '0;
      pend_seg_q <= '0;
      pend_dp_q  <= '0;
      pending_q  <= 1'b0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      enb_q      <= 6'b111111;
      start_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;

      // Accept and swap never coincide: accept needs pending clear, swap
      // needs it set.
      if (i_frame_valid && !pending_q) begin
        pend_seg_q <= i_frame_seg;
        pend_dp_q  <= i_frame_dp;
        pending_q  <= 1'b1;
      end

      if (slot_go) begin
        // Slot start: mask is consumed through the index choice, brightness
        // is frozen for the whole slot.
        state_q  <= BLANK;
        cnt_q    <= '0;
        idx_q    <= idx_d;
        bright_q <= i_bright;
        start_q  <= boundary;
        enb_q    <= 6'b111111;
        seg_q    <= '0;
        dp_q     <= 1'b0;
        if (boundary && pending_q) begin
          act_seg_q <= pend_seg_q;
          act_dp_q  <= pend_dp_q;
          pending_q <= 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            enb_q <= 6'b111111;
            seg_q <= '0;
            dp_q  <= 1'b0;
            if (pending_q) begin
              act_seg_q <= pend_seg_q;
              act_dp_q  <= pend_dp_q;
              pending_q <= 1'b0;
            end
          end
          BLANK: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == BLANK_LAST) begin
              if (bright_q != 4'd0) begin
                state_q <= ON;
                enb_q   <= ~(6'd1 << idx_q);
                seg_q   <= digit_seg[idx_q];
                dp_q    <= act_dp_q[idx_q];
              end else begin
                state_q <= OFF;
              end
            end
          end
          ON: begin
            cnt_q <= cnt_q + 1'b1;
            // Slot end with an empty mask (full brightness): fall to IDLE.
            if (cnt_q == SLOT_LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              enb_q   <= 6'b111111;
              seg_q   <= '0;
              dp_q    <= 1'b0;
            end else if (cnt_q == on_last) begin
              state_q <= OFF;
              enb_q   <= 6'b111111;
              seg_q   <= '0;
              dp_q    <= 1'b0;
            end
          end
          OFF: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == SLOT_LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign o_frame_ready = ~pending_q;
  assign o_seg         = seg_q;
  assign o_seg_dp      = dp_q;
  assign o_seg_enb     = enb_q;
  assign o_frame_start = start_q;

endmodule
